// File: rtl/instruction_fetch.sv
// Fetch stage: PC register driving the instruction ROM and a one-entry output register.
// Define FETCH_HALT_DETECT_EN to stop fetching after HALT_WORD has been delivered.
module instruction_fetch #(
    parameter int unsigned          WIDTH     = 32,
    parameter int unsigned          ADDR_BITS = 12,
    parameter logic [ADDR_BITS-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0]     HALT_WORD = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [ADDR_BITS-1:0] pc_addr,
    input  logic [WIDTH-1:0]     rom_data,
    output logic [WIDTH-1:0]     instr_out,
    output logic [ADDR_BITS-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 redirect_valid,
    input  logic [ADDR_BITS-1:0] redirect_addr,
    output logic                 halted
);

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HaltDetect = 1'b1;
`else
    localparam bit HaltDetect = 1'b0;
`endif

    typedef enum logic {StRun, StHalt} state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [ADDR_BITS-1:0] ipc_q, ipc_d;
    logic                 valid_q, valid_d;
    logic                 out_free;
    logic                 halt_hit;

    assign out_free = !valid_q || instr_ready;
    assign halt_hit = HaltDetect && (rom_data == HALT_WORD);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        if (redirect_valid) begin
            // Flush wins over any simultaneous accept or capture.
            pc_d    = redirect_addr;
            valid_d = 1'b0;
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (out_free) begin
                        out_d   = rom_data;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        if (halt_hit) begin
                            state_d = StHalt;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end
                StHalt: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    assign pc_addr     = pc_q;
    assign instr_out   = out_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign halted      = HaltDetect && (state_q == StHalt);

endmodule
